// File: rtl/compare_threshold_monitor.sv
// Debounced hysteresis alarm driven by the greater/equal/lesser flags of a magnitude comparator.
// It produces registered rise/fall pulses, a saturating rise count and an illegal-code flag.
module compare_threshold_monitor #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             greater,
  input  logic             equal,
  input  logic             lesser,
  input  logic             clr_cnt,
  output logic             alarm,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic             cnt_sat,
  output logic             code_err
);

  typedef enum logic [1:0] {LOW, ARM, HIGH, DISARM} state_t;

  localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] run, run_nxt, run_inc;
  logic       hi, lo, eq, err;
  logic       rise_nxt, fall_nxt;

  // Only the three one-hot codes are legal samples; everything else is reported.
  assign hi      = in_valid && ({greater, equal, lesser} == 3'b100);
  assign eq      = in_valid && ({greater, equal, lesser} == 3'b010);
  assign lo      = in_valid && ({greater, equal, lesser} == 3'b001);
  assign err     = in_valid && !(hi || eq || lo);
  assign run_inc = run + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOW;
      run        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      code_err   <= 1'b0;
      event_cnt  <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      code_err   <= err;
      // A clear coincident with a rise keeps that rise.
      if (clr_cnt) begin
        event_cnt <= CNT_W'(rise_nxt);
        cnt_sat   <= rise_nxt && (CNT_MAX == CNT_W'(1));
      end else if (rise_nxt && !cnt_sat) begin
        event_cnt <= event_cnt + 1'b1;
        if (event_cnt == CNT_MAX - 1'b1) cnt_sat <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: if (hi) begin
        if (DEB == 4'd1) begin
          state_nxt = HIGH;
          rise_nxt  = 1'b1;
        end else begin
          state_nxt = ARM;
          run_nxt   = 4'd1;
        end
      end
      ARM: if (hi) begin
        if (run_inc == DEB) begin
          state_nxt = HIGH;
          run_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          run_nxt   = run_inc;
        end
      end else if (lo) begin
        state_nxt = LOW;
        run_nxt   = '0;
      end
      HIGH: if (lo) begin
        if (DEB == 4'd1) begin
          state_nxt = LOW;
          fall_nxt  = 1'b1;
        end else begin
          state_nxt = DISARM;
          run_nxt   = 4'd1;
        end
      end
      DISARM: if (lo) begin
        if (run_inc == DEB) begin
          state_nxt = LOW;
          run_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          run_nxt   = run_inc;
        end
      end else if (hi) begin
        state_nxt = HIGH;
        run_nxt   = '0;
      end
      default: begin
        state_nxt = LOW;
        run_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    alarm = (state == HIGH) || (state == DISARM);
  end

endmodule
